// File: rtl/exec_wb_pipe.sv
// exec_wb_pipe: execute stage plus STAGES-deep register pipe to writeback with stall, flush and sticky halt
module exec_wb_pipe #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_pc,
  input  logic [3:0]             in_rt,
  input  logic [2:0]             in_op,
  input  logic                   in_vec,
  input  logic                   in_halt,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   wb_valid,
  output logic [15:0]            wb_pc,
  output logic [3:0]             wb_rt,
  output logic [LANES*WIDTH-1:0] wb_result,
  output logic                   wb_vec,
  output logic                   wb_illegal,
  output logic                   wb_halt,
  output logic                   wb_zero,
  output logic                   wb_sign,
  output logic                   busy,
  output logic                   halted
);
  localparam int VW = LANES * WIDTH;
  logic [STAGES-1:0] v, vec, ill, hlt;
  logic [15:0]       pc  [STAGES];
  logic [3:0]        rt  [STAGES];
  logic [VW-1:0]     res [STAGES];
  logic [WIDTH-1:0]  prod [LANES];
  logic [WIDTH-1:0]  dot;
  logic [VW-1:0]     alu;
  logic              illegal, accept;
  for (genvar l = 0; l < LANES; l++) begin : g_mul
    assign prod[l] = in_a[l*WIDTH +: WIDTH] * in_b[l*WIDTH +: WIDTH];
  end
  assign in_ready = !stall && !halted && !rst;
  assign accept   = in_valid && in_ready && !flush;
  assign illegal  = in_op > 3'd4;
  always_comb begin
    alu = '0;
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + prod[i];
      alu[i*WIDTH +: WIDTH] = !(i == 0 || in_vec) ? '0 :
                              in_op == 3'd0 ? in_a[i*WIDTH +: WIDTH] + in_b[i*WIDTH +: WIDTH] :
                              in_op == 3'd1 ? in_b[i*WIDTH +: WIDTH] - in_a[i*WIDTH +: WIDTH] :
                              in_op == 3'd2 ? prod[i] :
                              in_op == 3'd3 ? in_b[i*WIDTH +: WIDTH] : '0;
    end
    if (in_op == 3'd4) begin
      alu = '0;
      alu[WIDTH-1:0] = dot;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      vec    <= '0;
      ill    <= '0;
      hlt    <= '0;
      halted <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        pc[s]  <= '0;
        rt[s]  <= '0;
        res[s] <= '0;
      end
    end else begin
      if (wb_valid && !stall && wb_halt) halted <= 1'b1;
      if (flush) v <= '0;
      else if (!stall) begin
        v      <= {v[STAGES-2:0], accept};
        vec    <= {vec[STAGES-2:0], in_vec};
        ill    <= {ill[STAGES-2:0], illegal};
        hlt    <= {hlt[STAGES-2:0], in_halt};
        pc[0]  <= in_pc;
        rt[0]  <= in_rt;
        res[0] <= alu;
        for (int s = 1; s < STAGES; s++) begin
          pc[s]  <= pc[s-1];
          rt[s]  <= rt[s-1];
          res[s] <= res[s-1];
        end
      end
    end
  end
  assign wb_valid   = v[STAGES-1];
  assign wb_pc      = pc[STAGES-1];
  assign wb_rt      = rt[STAGES-1];
  assign wb_result  = res[STAGES-1];
  assign wb_vec     = vec[STAGES-1];
  assign wb_illegal = ill[STAGES-1];
  assign wb_halt    = hlt[STAGES-1];
  assign wb_zero    = res[STAGES-1][WIDTH-1:0] == '0;
  assign wb_sign    = res[STAGES-1][WIDTH-1];
  assign busy       = |v;
endmodule
